reg_file_mp: RTL and testbench

Parametrised multi-port register file, the successor of the single-write, two-read CPU register file. It provides a configurable number of combinational read ports and two synchronous write ports with a fixed priority. Same-cycle write-to-read bypass replaces the old negedge-write trick. A per-register pending (scoreboard) bit lets the decode stage detect read-after-write hazards. It sits between decode (read/issue) and writeback (write/clear) in the pipelined core.

---
 rtl/reg_file_mp.sv | 173 +++++++++++++++++
 tb/tb_reg_file_mp.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp
//  Description : Parametrised multi-port register file. It has NUM_RD
//                combinational read ports and two synchronous write ports
//                (port B has priority over port A). A same-cycle write is
//                bypassed to the readers. A per-register pending bit is
//                set on issue and cleared on writeback, and it drives the
//                busy hazard outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int WORD_LEN = 32,
    parameter int ADDR_LEN = 4,
    parameter int DEPTH    = 2**ADDR_LEN,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 writeEn,
    input  logic [2*ADDR_LEN-1:0]      dest,
    input  logic [2*WORD_LEN-1:0]      writeVal,
    input  logic [NUM_RD*ADDR_LEN-1:0] src,
    output logic [NUM_RD*WORD_LEN-1:0] rdVal,
    input  logic                       issueEn,
    input  logic [ADDR_LEN-1:0]        issueDest,
    output logic [NUM_RD-1:0]          busy
);

    localparam logic c_ZERO_EN = (ZERO_REG != 0);

    // ------------------------------------------------------------------
    // Address qualification helpers
    // ------------------------------------------------------------------
    function automatic logic f_in_range(input logic [ADDR_LEN-1:0] a);
        return (32'(a) < DEPTH);
    endfunction

    function automatic logic f_is_zero(input logic [ADDR_LEN-1:0] a);
        return c_ZERO_EN && (a == '0);
    endfunction

    // An address can hold state only if it exists and is not the
    // hardwired zero register.
    function automatic logic f_writable(input logic [ADDR_LEN-1:0] a);
        return f_in_range(a) && !f_is_zero(a);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WORD_LEN-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]    r_pending;

    // ------------------------------------------------------------------
    // Write port decode
    // ------------------------------------------------------------------
    logic [ADDR_LEN-1:0] w_dest_a;
    logic [ADDR_LEN-1:0] w_dest_b;
    logic [WORD_LEN-1:0] w_val_a;
    logic [WORD_LEN-1:0] w_val_b;
    logic                w_wr_ok_a;
    logic                w_wr_ok_b;
    logic                w_iss_ok;

    assign w_dest_a  = dest[ADDR_LEN-1:0];
    assign w_dest_b  = dest[2*ADDR_LEN-1:ADDR_LEN];
    assign w_val_a   = writeVal[WORD_LEN-1:0];
    assign w_val_b   = writeVal[2*WORD_LEN-1:WORD_LEN];

    // Effective writes and issues: enabled and aimed at a real register.
    // Reset gating is applied at the storage and at the read outputs.
    assign w_wr_ok_a = writeEn[0] && f_writable(w_dest_a);
    assign w_wr_ok_b = writeEn[1] && f_writable(w_dest_b);
    assign w_iss_ok  = issueEn    && f_writable(issueDest);

    logic [DEPTH-1:0] w_hit_a;
    logic [DEPTH-1:0] w_hit_b;
    logic [DEPTH-1:0] w_hit_iss;

    // One-hot per-register hit vectors for both write ports and issue
    always_comb begin
        w_hit_a   = '0;
        w_hit_b   = '0;
        w_hit_iss = '0;
        for (int r = 0; r < DEPTH; r++) begin
            w_hit_a[r]   = w_wr_ok_a && (w_dest_a  == ADDR_LEN'(r));
            w_hit_b[r]   = w_wr_ok_b && (w_dest_b  == ADDR_LEN'(r));
            w_hit_iss[r] = w_iss_ok  && (issueDest == ADDR_LEN'(r));
        end
    end

    // Storage and scoreboard update. Port B wins a same-address write and
    // an issue wins over a writeback clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_mem[r] <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (w_hit_b[r]) begin
                    r_mem[r] <= w_val_b;
                end else if (w_hit_a[r]) begin
                    r_mem[r] <= w_val_a;
                end

                if (w_hit_iss[r]) begin
                    r_pending[r] <= 1'b1;
                end else if (w_hit_a[r] || w_hit_b[r]) begin
                    r_pending[r] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_LEN-1:0] w_src;
        logic [WORD_LEN-1:0] w_mem_val;
        logic [WORD_LEN-1:0] w_val;
        logic                w_pend;
        logic                w_valid;
        logic                w_byp_a;
        logic                w_byp_b;
        logic                w_busy;

        assign w_src   = src[i*ADDR_LEN +: ADDR_LEN];
        assign w_valid = f_writable(w_src);
        assign w_byp_a = w_wr_ok_a && (w_dest_a == w_src);
        assign w_byp_b = w_wr_ok_b && (w_dest_b == w_src);

        // Storage mux: selected register contents and its pending bit
        always_comb begin
            w_mem_val = '0;
            w_pend    = 1'b0;
            for (int r = 0; r < DEPTH; r++) begin
                if (w_src == ADDR_LEN'(r)) begin
                    w_mem_val = r_mem[r];
                    w_pend    = r_pending[r];
                end
            end
        end

        // Read value priority: reset, invalid address, bypass B, bypass A,
        // then storage
        always_comb begin
            w_val = '0;
            if (rst || !w_valid) begin
                w_val = '0;
            end else if (w_byp_b) begin
                w_val = w_val_b;
            end else if (w_byp_a) begin
                w_val = w_val_a;
            end else begin
                w_val = w_mem_val;
            end
        end

        // A writeback presented this cycle resolves the hazard immediately
        // because the bypass already supplies the data.
        assign w_busy = !rst && w_valid && w_pend && !(w_byp_a || w_byp_b);

        assign rdVal[i*WORD_LEN +: WORD_LEN] = w_val;
        assign busy[i]                       = w_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_mp
//  Description : Self-checking bench for reg_file_mp. It drives a default
//                instance and a swept instance (NUM_RD=4, DEPTH=12,
//                ZERO_REG=0). Expected values are queued as the stimulus is
//                driven and are compared once the outputs settle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Default instance: WORD_LEN=32, ADDR_LEN=4, DEPTH=16, NUM_RD=2, ZERO_REG=1
    logic [1:0]  writeEn;
    logic [7:0]  dest;
    logic [63:0] writeVal;
    logic [7:0]  src;
    logic [63:0] rdVal;
    logic        issueEn;
    logic [3:0]  issueDest;
    logic [1:0]  busy;

    // Swept instance: NUM_RD=4, DEPTH=12, ADDR_LEN=4, ZERO_REG=0
    logic [1:0]   writeEn2;
    logic [7:0]   dest2;
    logic [63:0]  writeVal2;
    logic [15:0]  src2;
    logic [127:0] rdVal2;
    logic         issueEn2;
    logic [3:0]   issueDest2;
    logic [3:0]   busy2;

    reg_file_mp dut (
        .clk       (clk),
        .rst       (rst),
        .writeEn   (writeEn),
        .dest      (dest),
        .writeVal  (writeVal),
        .src       (src),
        .rdVal     (rdVal),
        .issueEn   (issueEn),
        .issueDest (issueDest),
        .busy      (busy)
    );

    reg_file_mp #(
        .WORD_LEN (32),
        .ADDR_LEN (4),
        .DEPTH    (12),
        .NUM_RD   (4),
        .ZERO_REG (0)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .writeEn   (writeEn2),
        .dest      (dest2),
        .writeVal  (writeVal2),
        .src       (src2),
        .rdVal     (rdVal2),
        .issueEn   (issueEn2),
        .issueDest (issueDest2),
        .busy      (busy2)
    );

    int checks   = 0;
    int failures = 0;

    localparam int c_K_RD   = 0;
    localparam int c_K_BUSY = 1;
    localparam int c_K_RD2  = 2;
    localparam int c_K_BSY2 = 3;

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int kind, input int port, input logic [31:0] e);
        exp_t t;
        t.tag  = tag;
        t.kind = kind;
        t.port = port;
        t.exp  = e;
        sb.push_back(t);
    endtask

    function automatic logic [31:0] observe(input int kind, input int port);
        case (kind)
            c_K_RD:   return rdVal[port*32 +: 32];
            c_K_BUSY: return {31'd0, busy[port]};
            c_K_RD2:  return rdVal2[port*32 +: 32];
            default:  return {31'd0, busy2[port]};
        endcase
    endfunction

    // Let combinational outputs settle, then compare every queued entry
    task automatic drain();
        exp_t t;
        #1;
        while (sb.size() > 0) begin
            t = sb.pop_front();
            check_val(t.tag, observe(t.kind, t.port), t.exp);
        end
    endtask

    // Start a new cycle just after the falling edge; enables are one-shot
    task automatic next();
        @(negedge clk);
        writeEn  = 2'b00;
        issueEn  = 1'b0;
        writeEn2 = 2'b00;
        issueEn2 = 1'b0;
    endtask

    task automatic wr_a(input logic [3:0] d, input logic [31:0] v);
        dest[3:0] = d; writeVal[31:0] = v; writeEn[0] = 1'b1;
    endtask
    task automatic wr_b(input logic [3:0] d, input logic [31:0] v);
        dest[7:4] = d; writeVal[63:32] = v; writeEn[1] = 1'b1;
    endtask
    task automatic wr2_a(input logic [3:0] d, input logic [31:0] v);
        dest2[3:0] = d; writeVal2[31:0] = v; writeEn2[0] = 1'b1;
    endtask
    task automatic wr2_b(input logic [3:0] d, input logic [31:0] v);
        dest2[7:4] = d; writeVal2[63:32] = v; writeEn2[1] = 1'b1;
    endtask
    task automatic issue(input logic [3:0] d);
        issueDest = d; issueEn = 1'b1;
    endtask
    task automatic issue2(input logic [3:0] d);
        issueDest2 = d; issueEn2 = 1'b1;
    endtask
    task automatic set_src(input int p, input logic [3:0] a);
        src[p*4 +: 4] = a;
    endtask
    task automatic set_src2(input int p, input logic [3:0] a);
        src2[p*4 +: 4] = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        writeEn    = '0; dest  = '0; writeVal  = '0; src  = '0;
        issueEn    = 1'b0; issueDest  = '0;
        writeEn2   = '0; dest2 = '0; writeVal2 = '0; src2 = '0;
        issueEn2   = 1'b0; issueDest2 = '0;
        repeat (2) @(posedge clk);

        // ---------------- Reset: fill, then reset ----------------
        next(); rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next();
            wr_a(4'(2*k), 32'hA5A5A5A5);
            wr_b(4'(2*k+1), 32'hA5A5A5A5);
            wr2_a(4'(2*k), 32'hA5A5A5A5);
            wr2_b(4'(2*k+1), 32'hA5A5A5A5);
        end
        next(); issue(4'd2); set_src(0, 4'd1); set_src(1, 4'd2);
        push("fill_r1", c_K_RD, 0, 32'hA5A5A5A5);
        push("busy_before_issue_edge", c_K_BUSY, 1, 32'd0);
        drain();
        next();
        push("busy_r2_pending", c_K_BUSY, 1, 32'd1);
        push("fill_r2", c_K_RD, 1, 32'hA5A5A5A5);
        drain();
        next(); rst = 1'b1; wr_a(4'd1, 32'h12345678);
        push("rst_rd0", c_K_RD, 0, 32'd0);
        push("rst_rd1", c_K_RD, 1, 32'd0);
        push("rst_busy1", c_K_BUSY, 1, 32'd0);
        drain();
        next(); rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next();
            set_src(0, 4'(2*k)); set_src(1, 4'(2*k+1));
            push("post_rst_rd0", c_K_RD, 0, 32'd0);
            push("post_rst_rd1", c_K_RD, 1, 32'd0);
            push("post_rst_busy0", c_K_BUSY, 0, 32'd0);
            push("post_rst_busy1", c_K_BUSY, 1, 32'd0);
            if (k < 3) begin
                for (int p = 0; p < 4; p++) begin
                    set_src2(p, 4'(4*k+p));
                    push("post_rst_rd2", c_K_RD2, p, 32'd0);
                end
            end
            drain();
        end

        // ---------------- Zero register ----------------
        next(); wr_a(4'd0, 32'hFFFFFFFF); issue(4'd0); set_src(0, 4'd0);
        push("zero_bypass", c_K_RD, 0, 32'd0);
        push("zero_busy", c_K_BUSY, 0, 32'd0);
        drain();
        next();
        push("zero_stored", c_K_RD, 0, 32'd0);
        push("zero_busy_after", c_K_BUSY, 0, 32'd0);
        drain();

        // ---------------- Dual write, port B wins ----------------
        next(); wr_a(4'd5, 32'h11); wr_b(4'd5, 32'h22); set_src(1, 4'd5);
        push("dual_bypass", c_K_RD, 1, 32'h22);
        drain();
        next();
        push("dual_stored", c_K_RD, 1, 32'h22);
        drain();

        // ---------------- Bypass ----------------
        next(); set_src(0, 4'd3);
        push("byp_before", c_K_RD, 0, 32'd0);
        drain();
        wr_a(4'd3, 32'hDEADBEEF);
        push("byp_same_cycle", c_K_RD, 0, 32'hDEADBEEF);
        drain();
        next();
        push("byp_stored", c_K_RD, 0, 32'hDEADBEEF);
        drain();

        // ---------------- Scoreboard lifetime ----------------
        next(); issue(4'd7); set_src(1, 4'd7);
        push("sb_busy_pre", c_K_BUSY, 1, 32'd0);
        drain();
        for (int c = 0; c < 3; c++) begin
            next();
            push("sb_busy_held", c_K_BUSY, 1, 32'd1);
            drain();
        end
        next(); wr_a(4'd7, 32'h42);
        push("sb_busy_wb", c_K_BUSY, 1, 32'd0);
        push("sb_rd_wb", c_K_RD, 1, 32'h42);
        drain();
        next();
        push("sb_busy_cleared", c_K_BUSY, 1, 32'd0);
        push("sb_rd_stored", c_K_RD, 1, 32'h42);
        drain();

        // ---------------- Issue/write collision ----------------
        next(); issue(4'd4); set_src(0, 4'd4);
        next();
        push("col_pending", c_K_BUSY, 0, 32'd1);
        drain();
        issue(4'd4); wr_b(4'd4, 32'h9);
        push("col_busy_wb", c_K_BUSY, 0, 32'd0);
        push("col_rd_wb", c_K_RD, 0, 32'h9);
        drain();
        next();
        push("col_rd_after", c_K_RD, 0, 32'h9);
        push("col_busy_after", c_K_BUSY, 0, 32'd1);
        drain();

        // ---------------- Parameter sweep instance ----------------
        next(); wr2_a(4'd0, 32'h1); set_src2(0, 4'd0);
        push("sw_r0_bypass", c_K_RD2, 0, 32'h1);
        drain();
        next();
        push("sw_r0_stored", c_K_RD2, 0, 32'h1);
        drain();
        next(); wr2_a(4'd13, 32'h77); wr2_b(4'd11, 32'hBB); issue2(4'd13);
        set_src2(1, 4'd13); set_src2(3, 4'd11);
        push("sw_r13_bypass", c_K_RD2, 1, 32'd0);
        push("sw_r13_busy", c_K_BSY2, 1, 32'd0);
        push("sw_r11_bypass", c_K_RD2, 3, 32'hBB);
        drain();
        next();
        push("sw_r13_rd", c_K_RD2, 1, 32'd0);
        push("sw_r13_busy_after", c_K_BSY2, 1, 32'd0);
        push("sw_r11_stored", c_K_RD2, 3, 32'hBB);
        drain();
        next(); issue2(4'd0); set_src2(2, 4'd0);
        push("sw_r0_busy_pre", c_K_BSY2, 2, 32'd0);
        drain();
        next();
        push("sw_r0_busy", c_K_BSY2, 2, 32'd1);
        push("sw_r0_rd_p2", c_K_RD2, 2, 32'h1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
